rtx_scan_controller: RTL and testbench

RTX_SCAN_CONTROLLER -- requirements
Module: rtx_scan_controller

---
 rtl/rtx_scan_controller.sv | 100 ++++++++++
 tb/tb_rtx_scan_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtx_scan_controller.sv
// Raster scan controller: requests one ray per pixel in raster order, waits for
// the tracer result and hands it to the framebuffer with a held write request.
module rtx_scan_controller #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  localparam int AW    = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          continuous,
  input  logic          ray_done,
  input  logic [15:0]   rtx_pixel,
  input  logic          fb_ready,
  output logic [10:0]   pixel_h_out,
  output logic [9:0]    pixel_v_out,
  output logic          new_ray,
  output logic [AW-1:0] fb_addr,
  output logic [15:0]   fb_data,
  output logic          fb_we,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

  localparam logic [10:0] H_LAST = 11'(WIDTH - 1);
  localparam logic [9:0]  V_LAST = 10'(HEIGHT - 1);

  state_t        state, state_next;
  logic [10:0]   h_q;
  logic [9:0]    v_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   data_q;
  logic [15:0]   count_q;
  logic          last_pixel;
  logic          xfer;
  logic          frame_load;

  assign last_pixel = (h_q == H_LAST) && (v_q == V_LAST);
  assign xfer       = (state == WRITE) && fb_ready;
  assign frame_load = ((state == IDLE) && start) || ((state == DONE) && continuous);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (ray_done) state_next = WRITE;
      WRITE:   if (fb_ready) state_next = last_pixel ? DONE : ISSUE;
      DONE:    state_next = continuous ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address advances alongside the coordinates so no v*WIDTH product is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      if (frame_load) begin
        h_q    <= '0;
        v_q    <= '0;
        addr_q <= '0;
      end
      if ((state == WAIT) && ray_done) data_q <= rtx_pixel;
      if (xfer && !last_pixel) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          v_q <= v_q + 10'd1;
        end else begin
          h_q <= h_q + 11'd1;
        end
        addr_q <= addr_q + AW'(1);
      end
      if (xfer && last_pixel) count_q <= count_q + 16'd1;
    end
  end

  assign pixel_h_out = h_q;
  assign pixel_v_out = v_q;
  assign fb_addr     = addr_q;
  assign fb_data     = data_q;
  assign frame_count = count_q;
  assign new_ray     = (state == ISSUE);
  assign fb_we       = (state == WRITE);
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);

endmodule

// File: tb/tb_rtx_scan_controller.sv
// Bench for rtx_scan_controller: a 4x2 instance driven by a tracer/framebuffer
// model with random latency, backpressure and data, plus a 1x1 instance for wrap.
module tb_rtx_scan_controller;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst, start, continuous, ray_done, fb_ready;
  logic [15:0] rtx_pixel;
  logic [10:0] pixel_h_out;
  logic [9:0]  pixel_v_out;
  logic        new_ray, fb_we, busy, frame_done;
  logic [2:0]  fb_addr;
  logic [15:0] fb_data, frame_count;

  logic        clk_s = 1'b0;
  logic        rst_s, start_s, continuous_s, ray_done_s, fb_ready_s;
  logic [15:0] rtx_pixel_s;
  logic [10:0] pixel_h_out_s;
  logic [9:0]  pixel_v_out_s;
  logic        new_ray_s, fb_we_s, busy_s, frame_done_s;
  logic [0:0]  fb_addr_s;
  logic [15:0] fb_data_s, frame_count_s;

  rtx_scan_controller #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .ray_done(ray_done), .rtx_pixel(rtx_pixel), .fb_ready(fb_ready),
    .pixel_h_out(pixel_h_out), .pixel_v_out(pixel_v_out), .new_ray(new_ray),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  rtx_scan_controller #(.WIDTH(1), .HEIGHT(1)) dut_small (
    .clk(clk_s), .rst(rst_s), .start(start_s), .continuous(continuous_s),
    .ray_done(ray_done_s), .rtx_pixel(rtx_pixel_s), .fb_ready(fb_ready_s),
    .pixel_h_out(pixel_h_out_s), .pixel_v_out(pixel_v_out_s), .new_ray(new_ray_s),
    .fb_addr(fb_addr_s), .fb_data(fb_data_s), .fb_we(fb_we_s), .busy(busy_s),
    .frame_done(frame_done_s), .frame_count(frame_count_s)
  );

  always #5 clk = ~clk;
  always #2 clk_s = ~clk_s;

  int          n_assert = 0;
  int          n_fail = 0;
  int          trace_cnt = 0;
  int          lat_min = 1, lat_max = 1, ready_pct = 100;
  bit          rand_data = 0, spur_rd = 0, spur_start = 0;
  bit          in_flight = 0, expect_we = 0, expect_after_xfer = 0, after_last = 0, we_pending = 0;
  int          writes_in_frame = 0, frames_seen = 0;
  int          bp_addr = -1, bp_left = 0;
  logic [15:0] exp_fc = '0;
  logic [15:0] exp_pix = '0;
  logic [23:0] lat_pos = '0;
  logic [23:0] ray_q[$];
  logic [2:0]  wr_a[$];
  logic [15:0] wr_d[$];
  logic [15:0] sent_pix[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {4'(0), new_ray, fb_we, frame_done, busy, pixel_h_out, pixel_v_out, fb_addr}, 0);
    checkOutput({tag, "_data"}, {fb_data, frame_count}, 0);
  endtask

  // One clock of the environment: observe the DUT, then drive inputs for the next edge.
  task automatic applyStimulus();
    bit          rst_edge;
    logic [15:0] pix;
    rst_edge = rst;
    @(posedge clk);
    #1;
    if (rst_edge) begin
      in_flight = 0; we_pending = 0; expect_we = 0; expect_after_xfer = 0;
      writes_in_frame = 0; exp_fc = '0;
    end else begin
      if (expect_we) checkOutput("fb_we_after_ray_done", fb_we, 1);
      if (we_pending) checkOutput("fb_we_held", fb_we, 1);
      checkOutput("frame_done_pulse", frame_done, expect_after_xfer && after_last);
      if (expect_after_xfer && !after_last) checkOutput("new_ray_after_xfer", new_ray, 1);
      if (frame_done) frames_seen++;
      if (new_ray) begin
        checkOutput("one_ray_in_flight", in_flight, 0);
        lat_pos = {pixel_h_out, pixel_v_out, fb_addr};
        ray_q.push_back(lat_pos);
        in_flight = 1;
        trace_cnt = lat_min + int'($urandom_range(lat_max - lat_min)) + 1;
      end else if (in_flight) begin
        checkOutput("pos_stable", {pixel_h_out, pixel_v_out, fb_addr}, lat_pos);
      end
      if (in_flight) checkOutput("busy_in_frame", busy, 1);
      else checkOutput("no_stray_we", fb_we, 0);
    end
    expect_we = 0; expect_after_xfer = 0; we_pending = 0;

    ray_done  = 1'b0;
    rtx_pixel = 16'($urandom);
    if (trace_cnt > 0) begin
      trace_cnt--;
      if (trace_cnt == 0) begin
        pix = rand_data ? 16'($urandom) : 16'h100 + 16'(lat_pos[2:0]);
        ray_done  = 1'b1;
        rtx_pixel = pix;
        if (in_flight) begin
          expect_we = 1;
          exp_pix = pix;
          sent_pix.push_back(pix);
        end
      end
    end else if (spur_rd && fb_we && !rst_edge) begin
      ray_done  = 1'b1;
      rtx_pixel = 16'hDEAD;
    end

    fb_ready = ($urandom_range(99) < ready_pct);
    if (fb_we && bp_left > 0 && int'(fb_addr) == bp_addr) begin
      fb_ready = 1'b0;
      bp_left--;
    end
    if (in_flight && fb_we) begin
      checkOutput("fb_data_stable", fb_data, exp_pix);
      if (fb_ready) begin
        checkOutput("write_addr_raster", fb_addr, writes_in_frame);
        wr_a.push_back(fb_addr);
        wr_d.push_back(fb_data);
        writes_in_frame++;
        in_flight = 0;
        expect_after_xfer = 1;
        after_last = (writes_in_frame == NPIX);
        if (after_last) begin
          writes_in_frame = 0;
          exp_fc++;
        end
      end else begin
        we_pending = 1;
      end
    end

    start = 1'b0;
    if (spur_start && !rst_edge && ((new_ray && pixel_h_out == 11'd3) || frame_done)) start = 1'b1;
  endtask

  task automatic run_frames(input int n_frames, input int cont_frames, input int budget);
    int base, n;
    base = frames_seen;
    n = 0;
    while (frames_seen < base + n_frames && n < budget) begin
      applyStimulus();
      n++;
      if (frames_seen - base >= cont_frames && !frame_done) continuous = 1'b0;
    end
    checkOutput("frames_completed", frames_seen, base + n_frames);
    applyStimulus();
    checkOutput("idle_after_frame", busy, 0);
    checkOutput("frame_count", frame_count, exp_fc);
  endtask

  // Expected order is the plain raster walk k -> (k%W, k/W) with address k.
  task automatic checkRaster(input int n, input bit fixed_data);
    logic [15:0] d;
    checkOutput("ray_count", ray_q.size(), n);
    checkOutput("write_count", wr_a.size(), n);
    for (int k = 0; k < n && k < ray_q.size(); k++)
      checkOutput("ray_raster", ray_q[k], {11'(k % W), 10'((k % NPIX) / W), 3'(k % NPIX)});
    for (int k = 0; k < n && k < wr_a.size(); k++) begin
      checkOutput("write_addr", wr_a[k], k % NPIX);
      d = fixed_data ? 16'h100 + 16'(k % NPIX) : ((k < sent_pix.size()) ? sent_pix[k] : 16'hxxxx);
      checkOutput("write_data", wr_d[k], d);
    end
    ray_q.delete(); wr_a.delete(); wr_d.delete(); sent_pix.delete();
  endtask

  initial begin
    int n, n_done, chk;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; ray_done = 1'b0; fb_ready = 1'b0; rtx_pixel = '0;
    rst_s = 1'b1; start_s = 1'b0; continuous_s = 1'b1; ray_done_s = 1'b1; fb_ready_s = 1'b1;
    rtx_pixel_s = 16'h1234;
    applyStimulus();
    applyStimulus();
    checkAllZero("reset");
    rst = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("idle_without_start", busy, 0);

    lat_min = 5; lat_max = 5; ready_pct = 100; rand_data = 0;
    start = 1'b1;
    run_frames(1, 0, 200);
    checkRaster(NPIX, 1);

    bp_addr = 2; bp_left = 4;
    start = 1'b1;
    run_frames(1, 0, 200);
    checkOutput("backpressure_applied", bp_left, 0);
    checkRaster(NPIX, 1);
    bp_addr = -1;

    lat_min = 1; lat_max = 3;
    continuous = 1'b1;
    start = 1'b1;
    run_frames(3, 2, 600);
    checkRaster(3 * NPIX, 1);

    ray_done = 1'b1; rtx_pixel = 16'hBEEF;
    applyStimulus();
    checkOutput("idle_ignores_ray_done", busy, 0);
    applyStimulus();
    spur_rd = 1; spur_start = 1; ready_pct = 50;
    start = 1'b1;
    run_frames(1, 0, 400);
    checkRaster(NPIX, 1);
    spur_rd = 0; spur_start = 0;

    lat_min = 1; lat_max = 6; ready_pct = 60; rand_data = 1;
    repeat (2) begin
      start = 1'b1;
      run_frames(1, 0, 400);
    end
    checkRaster(2 * NPIX, 0);

    lat_min = 4; lat_max = 4; ready_pct = 100; rand_data = 0;
    start = 1'b1;
    n = 0;
    while (ray_q.size() < 6 && n < 200) begin
      applyStimulus();
      n++;
    end
    checkOutput("reached_pixel_1_1", ray_q.size(), 6);
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkAllZero("mid_frame_reset");
    repeat (5) applyStimulus();
    checkOutput("no_ray_after_reset", ray_q.size(), 6);
    checkOutput("idle_after_reset", busy, 0);
    ray_q.delete(); wr_a.delete(); wr_d.delete(); sent_pix.delete();
    start = 1'b1;
    run_frames(1, 0, 200);
    checkRaster(NPIX, 1);

    // 1x1 frames run back to back until the 16-bit frame counter rolls over.
    repeat (2) @(posedge clk_s);
    #1 rst_s = 1'b0; start_s = 1'b1;
    @(posedge clk_s);
    #1 start_s = 1'b0;
    n = 0; n_done = 0; chk = 0;
    while ((n_done < 65536 || chk != 0) && n < 65536 * 4 + 200) begin
      @(posedge clk_s);
      #1;
      n++;
      if (chk == 1) checkOutput("wrap_ffff", frame_count_s, 16'hFFFF);
      else if (chk == 2) checkOutput("wrap_zero", frame_count_s, 16'h0000);
      chk = 0;
      if (frame_done_s) begin
        n_done++;
        if (n_done == 65535) chk = 1;
        else if (n_done == 65536) chk = 2;
      end
    end
    checkOutput("wrap_frames", n_done, 65536);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
